regfile_write_arbiter: RTL and testbench



---
 rtl/regfile_write_arbiter_if.sv | 48 ++++
 rtl/regfile_write_arbiter.sv | 156 +++++++++++++++
 tb/tb_regfile_write_arbiter.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/regfile_write_arbiter_if.sv
// Register file write arbiter bus: writeback, multi-cycle result channel,
// issue/decode scoreboard taps and the register file write port.
interface regfile_write_arbiter_if #(
    parameter int unsigned ADDRESS_WIDTH = 5,
    parameter int unsigned DATA_WIDTH    = 32
);
    // In-order pipeline writeback
    logic                     wb_we_i;
    logic [ADDRESS_WIDTH-1:0] wb_addr_i;
    logic [DATA_WIDTH-1:0]    wb_wd_i;
    logic                     wb_stall_o;

    // Multi-cycle unit result channel (valid/ready)
    logic                     mc_valid_i;
    logic                     mc_ready_o;
    logic [ADDRESS_WIDTH-1:0] mc_addr_i;
    logic [DATA_WIDTH-1:0]    mc_wd_i;

    // Issue and decode hazard lookup
    logic                     issue_i;
    logic [ADDRESS_WIDTH-1:0] issue_addr_i;
    logic [ADDRESS_WIDTH-1:0] rs1_addr_i;
    logic [ADDRESS_WIDTH-1:0] rs2_addr_i;
    logic                     hazard_o;

    // Register file write port
    logic                     rf_we_o;
    logic [ADDRESS_WIDTH-1:0] rf_addr_o;
    logic [DATA_WIDTH-1:0]    rf_wd_o;

    // Arbiter side
    modport slave (
        input  wb_we_i, wb_addr_i, wb_wd_i,
        input  mc_valid_i, mc_addr_i, mc_wd_i,
        input  issue_i, issue_addr_i, rs1_addr_i, rs2_addr_i,
        output wb_stall_o, mc_ready_o, hazard_o,
        output rf_we_o, rf_addr_o, rf_wd_o
    );

    // Pipeline / multi-cycle unit / register file side
    modport master (
        output wb_we_i, wb_addr_i, wb_wd_i,
        output mc_valid_i, mc_addr_i, mc_wd_i,
        output issue_i, issue_addr_i, rs1_addr_i, rs2_addr_i,
        input  wb_stall_o, mc_ready_o, hazard_o,
        input  rf_we_o, rf_addr_o, rf_wd_o
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Shares the single register file write port between pipeline writeback and
// a multi-cycle unit. Multi-cycle results are buffered in a small FIFO and
// drain whenever writeback is idle; a starvation counter forces a one-cycle
// writeback stall so the FIFO cannot be blocked forever. A pending scoreboard
// flags read-after-write hazards to decode.
module regfile_write_arbiter #(
    parameter int unsigned ADDRESS_WIDTH = 5,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned FIFO_DEPTH    = 2,
    parameter int unsigned STARVE_LIMIT  = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    regfile_write_arbiter_if.slave bus
);

    localparam int unsigned NUM_REGS = 1 << ADDRESS_WIDTH;
    localparam int unsigned PTR_W    = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W    = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned STV_W    = $clog2(STARVE_LIMIT + 1);

    // FIFO storage; kill marks an entry superseded by a younger writeback
    logic [ADDRESS_WIDTH-1:0] fifo_addr_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]    fifo_data_q [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]    fifo_kill_q;

    logic [PTR_W-1:0]         rd_ptr_q;
    logic [PTR_W-1:0]         wr_ptr_q;
    logic [CNT_W-1:0]         count_q;
    logic [STV_W-1:0]         starve_q;
    logic [NUM_REGS-1:0]      pending_q;
    logic [NUM_REGS-1:0]      pending_d;

    logic                     rf_we_q;
    logic [ADDRESS_WIDTH-1:0] rf_addr_q;
    logic [DATA_WIDTH-1:0]    rf_wd_q;
    logic                     wb_stall_q;

    logic                     fifo_empty_c;
    logic                     ready_c;
    logic                     wbe_c;
    logic                     push_c;
    logic                     pop_c;
    logic                     hazard_c;
    logic [ADDRESS_WIDTH-1:0] head_addr_c;
    logic [DATA_WIDTH-1:0]    head_data_c;
    logic                     head_kill_c;

    // Handshake, effective writeback and drain decisions
    always_comb begin
        fifo_empty_c = (count_q == '0);
        ready_c      = !rst_i && (count_q < CNT_W'(FIFO_DEPTH));
        wbe_c        = bus.wb_we_i && (bus.wb_addr_i != '0) && !wb_stall_q;
        push_c       = bus.mc_valid_i && ready_c;
        pop_c        = !wbe_c && !fifo_empty_c;
        head_addr_c  = fifo_addr_q[rd_ptr_q];
        head_data_c  = fifo_data_q[rd_ptr_q];
        head_kill_c  = fifo_kill_q[rd_ptr_q];
    end

    // Scoreboard next state: a same-edge issue overrides the drain clear
    always_comb begin
        pending_d = pending_q;
        if (pop_c) begin
            pending_d[head_addr_c] = 1'b0;
        end
        if (bus.issue_i && (bus.issue_addr_i != '0)) begin
            pending_d[bus.issue_addr_i] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    // Decode hazard: register 0 is never pending
    always_comb begin
        hazard_c = ((bus.rs1_addr_i != '0) && pending_q[bus.rs1_addr_i]) ||
                   ((bus.rs2_addr_i != '0) && pending_q[bus.rs2_addr_i]);
    end

    // FIFO payload; slots outside the valid window are overwritten on push,
    // so killing any matching slot is equivalent to killing valid ones only
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (wbe_c && (fifo_addr_q[PTR_W'(i)] == bus.wb_addr_i)) begin
                fifo_kill_q[PTR_W'(i)] <= 1'b1;
            end
        end
        if (push_c) begin
            fifo_addr_q[wr_ptr_q] <= bus.mc_addr_i;
            fifo_data_q[wr_ptr_q] <= bus.mc_wd_i;
            fifo_kill_q[wr_ptr_q] <= wbe_c && (bus.mc_addr_i == bus.wb_addr_i);
        end
    end

    // Write port mux, FIFO pointers, starvation counter and scoreboard
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            starve_q   <= '0;
            pending_q  <= '0;
            rf_we_q    <= 1'b0;
            rf_addr_q  <= '0;
            rf_wd_q    <= '0;
            wb_stall_q <= 1'b0;
        end else begin
            wb_stall_q <= 1'b0;

            if (wbe_c) begin
                rf_we_q   <= 1'b1;
                rf_addr_q <= bus.wb_addr_i;
                rf_wd_q   <= bus.wb_wd_i;
            end else if (pop_c) begin
                rf_we_q   <= !head_kill_c && (head_addr_c != '0);
                rf_addr_q <= head_addr_c;
                rf_wd_q   <= head_data_c;
                rd_ptr_q  <= rd_ptr_q + PTR_W'(1);
            end else begin
                rf_we_q   <= 1'b0;
            end

            if (push_c) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end

            if (push_c && !pop_c) begin
                count_q <= count_q + CNT_W'(1);
            end else if (pop_c && !push_c) begin
                count_q <= count_q - CNT_W'(1);
            end

            // Non-empty and not popping means writeback blocked the drain
            if (fifo_empty_c || pop_c) begin
                starve_q <= '0;
            end else if (starve_q == STV_W'(STARVE_LIMIT - 1)) begin
                starve_q   <= '0;
                wb_stall_q <= 1'b1;
            end else begin
                starve_q <= starve_q + STV_W'(1);
            end

            pending_q <= pending_d;
        end
    end

    // Port drive
    always_comb begin
        bus.mc_ready_o = ready_c;
        bus.hazard_o   = hazard_c;
        bus.wb_stall_o = wb_stall_q;
        bus.rf_we_o    = rf_we_q;
        bus.rf_addr_o  = rf_addr_q;
        bus.rf_wd_o    = rf_wd_q;
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: writeback path, multi-cycle
// path, WAW kill under starvation, backpressure, reset and scoreboard corner.
module tb_regfile_write_arbiter;

    localparam int unsigned AW = 5;
    localparam int unsigned DW = 32;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_errors;
    logic [DW-1:0] shadow [32];

    regfile_write_arbiter_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    regfile_write_arbiter #(
        .ADDRESS_WIDTH (AW),
        .DATA_WIDTH    (DW),
        .FIFO_DEPTH    (2),
        .STARVE_LIMIT  (4)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Architectural register file image built from the write port
    always @(posedge clk) begin
        if (bus.rf_we_o) shadow[bus.rf_addr_o] <= bus.rf_wd_o;
    end

    task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_tests  = 0;
        n_errors = 0;
        for (int i = 0; i < 32; i++) shadow[i] = '0;
        rst              = 1'b1;
        bus.wb_we_i      = 1'b0;
        bus.wb_addr_i    = '0;
        bus.wb_wd_i      = '0;
        bus.mc_valid_i   = 1'b0;
        bus.mc_addr_i    = '0;
        bus.mc_wd_i      = '0;
        bus.issue_i      = 1'b0;
        bus.issue_addr_i = '0;
        bus.rs1_addr_i   = '0;
        bus.rs2_addr_i   = '0;

        // Reset state
        tick();
        tick();
        check_eq("rst_rf_we",   32'(bus.rf_we_o),    32'd0);
        check_eq("rst_rf_addr", 32'(bus.rf_addr_o),  32'd0);
        check_eq("rst_rf_wd",   bus.rf_wd_o,         32'd0);
        check_eq("rst_stall",   32'(bus.wb_stall_o), 32'd0);
        check_eq("rst_ready",   32'(bus.mc_ready_o), 32'd0);
        rst = 1'b0;
        #1;
        check_eq("post_rst_ready", 32'(bus.mc_ready_o), 32'd1);

        // 1. Writeback path, then a dropped write to register 0
        bus.wb_we_i = 1'b1; bus.wb_addr_i = 5'd5; bus.wb_wd_i = 32'hDEADBEEF;
        tick();
        check_eq("wb_we",   32'(bus.rf_we_o),   32'd1);
        check_eq("wb_addr", 32'(bus.rf_addr_o), 32'd5);
        check_eq("wb_wd",   bus.rf_wd_o,        32'hDEADBEEF);
        bus.wb_addr_i = 5'd0; bus.wb_wd_i = 32'h1111;
        tick();
        check_eq("wb_r0_we",   32'(bus.rf_we_o),   32'd0);
        check_eq("wb_r0_hold", 32'(bus.rf_addr_o), 32'd5);
        bus.wb_we_i = 1'b0;

        // 2. Multi-cycle path with hazard tracking
        bus.issue_i = 1'b1; bus.issue_addr_i = 5'd7;
        tick();
        bus.issue_i = 1'b0;
        bus.rs1_addr_i = 5'd7;
        #1;
        check_eq("haz_rs1", 32'(bus.hazard_o), 32'd1);
        bus.rs1_addr_i = 5'd0; bus.rs2_addr_i = 5'd7;
        #1;
        check_eq("haz_rs2", 32'(bus.hazard_o), 32'd1);
        bus.rs2_addr_i = 5'd0;
        #1;
        check_eq("haz_r0", 32'(bus.hazard_o), 32'd0);
        bus.rs1_addr_i = 5'd7;
        bus.mc_valid_i = 1'b1; bus.mc_addr_i = 5'd7; bus.mc_wd_i = 32'h1234;
        tick();
        bus.mc_valid_i = 1'b0;
        check_eq("mc_lat_early", 32'(bus.rf_we_o), 32'd0);
        check_eq("mc_haz_held",  32'(bus.hazard_o), 32'd1);
        tick();
        check_eq("mc_we",    32'(bus.rf_we_o),   32'd1);
        check_eq("mc_addr",  32'(bus.rf_addr_o), 32'd7);
        check_eq("mc_wd",    bus.rf_wd_o,        32'h1234);
        check_eq("mc_haz_clr", 32'(bus.hazard_o), 32'd0);
        tick();
        check_eq("mc_we_done", 32'(bus.rf_we_o), 32'd0);

        // Multi-cycle result to register 0 drains without a write
        bus.mc_valid_i = 1'b1; bus.mc_addr_i = 5'd0; bus.mc_wd_i = 32'h77;
        tick();
        bus.mc_valid_i = 1'b0;
        tick();
        check_eq("mc_r0_we", 32'(bus.rf_we_o), 32'd0);
        check_eq("mc_r0_wd", bus.rf_wd_o,      32'h77);

        // 3. WAW conflict under starvation
        bus.mc_valid_i = 1'b1; bus.mc_addr_i = 5'd3; bus.mc_wd_i = 32'hAAAA;
        bus.wb_we_i = 1'b1; bus.wb_addr_i = 5'd3; bus.wb_wd_i = 32'h5555;
        tick();
        bus.mc_valid_i = 1'b0;
        tick(); tick(); tick();
        check_eq("starve_no_stall", 32'(bus.wb_stall_o), 32'd0);
        tick();
        check_eq("starve_stall", 32'(bus.wb_stall_o), 32'd1);
        check_eq("starve_wb_we", 32'(bus.rf_we_o),    32'd1);
        tick();
        check_eq("kill_we",       32'(bus.rf_we_o),    32'd0);
        check_eq("kill_wd",       bus.rf_wd_o,         32'hAAAA);
        check_eq("stall_one_cyc", 32'(bus.wb_stall_o), 32'd0);
        bus.wb_we_i = 1'b0;
        tick();
        check_eq("waw_reg3", shadow[3], 32'h5555);

        // 4. Backpressure with writeback busy
        bus.wb_we_i = 1'b1; bus.wb_addr_i = 5'd10; bus.wb_wd_i = 32'h100;
        bus.mc_valid_i = 1'b1; bus.mc_addr_i = 5'd11; bus.mc_wd_i = 32'hA1;
        tick();
        bus.mc_addr_i = 5'd12; bus.mc_wd_i = 32'hB2;
        tick();
        check_eq("bp_full", 32'(bus.mc_ready_o), 32'd0);
        bus.mc_addr_i = 5'd13; bus.mc_wd_i = 32'hC3;
        tick(); tick(); tick();
        check_eq("bp_stall",     32'(bus.wb_stall_o), 32'd1);
        check_eq("bp_still_full", 32'(bus.mc_ready_o), 32'd0);
        tick();
        check_eq("bp_pop_a_addr", 32'(bus.rf_addr_o), 32'd11);
        check_eq("bp_pop_a_wd",   bus.rf_wd_o,        32'hA1);
        check_eq("bp_ready",      32'(bus.mc_ready_o), 32'd1);
        tick();
        check_eq("bp_wb_addr", 32'(bus.rf_addr_o), 32'd10);
        bus.mc_valid_i = 1'b0; bus.wb_we_i = 1'b0;
        tick();
        check_eq("bp_pop_b_we",   32'(bus.rf_we_o),   32'd1);
        check_eq("bp_pop_b_addr", 32'(bus.rf_addr_o), 32'd12);
        check_eq("bp_pop_b_wd",   bus.rf_wd_o,        32'hB2);
        tick();
        check_eq("bp_pop_c_addr", 32'(bus.rf_addr_o), 32'd13);
        check_eq("bp_pop_c_wd",   bus.rf_wd_o,        32'hC3);
        tick();
        check_eq("bp_idle_we", 32'(bus.rf_we_o), 32'd0);

        // 5. Reset mid-operation
        bus.issue_i = 1'b1; bus.issue_addr_i = 5'd7;
        bus.wb_we_i = 1'b1; bus.wb_addr_i = 5'd20; bus.wb_wd_i = 32'h2020;
        bus.mc_valid_i = 1'b1; bus.mc_addr_i = 5'd21; bus.mc_wd_i = 32'h21;
        tick();
        bus.issue_i = 1'b0;
        bus.mc_addr_i = 5'd22; bus.mc_wd_i = 32'h22;
        tick();
        bus.mc_valid_i = 1'b0; bus.wb_we_i = 1'b0;
        bus.rs1_addr_i = 5'd7;
        #1;
        check_eq("mr_haz_before", 32'(bus.hazard_o), 32'd1);
        rst = 1'b1;
        #1;
        check_eq("mr_ready_in_rst", 32'(bus.mc_ready_o), 32'd0);
        tick();
        check_eq("mr_rf_we",   32'(bus.rf_we_o),   32'd0);
        check_eq("mr_rf_addr", 32'(bus.rf_addr_o), 32'd0);
        rst = 1'b0;
        #1;
        check_eq("mr_haz_after", 32'(bus.hazard_o),   32'd0);
        check_eq("mr_ready",     32'(bus.mc_ready_o), 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("mr_no_write", 32'(bus.rf_we_o), 32'd0);
        end
        check_eq("mr_reg21", shadow[21], 32'd0);
        check_eq("mr_reg22", shadow[22], 32'd0);

        // 6. Same-edge set and clear of one pending bit
        bus.rs1_addr_i = 5'd9;
        bus.issue_i = 1'b1; bus.issue_addr_i = 5'd9;
        bus.mc_valid_i = 1'b1; bus.mc_addr_i = 5'd9; bus.mc_wd_i = 32'h99;
        tick();
        bus.mc_valid_i = 1'b0;
        tick();
        check_eq("sc_pop_addr", 32'(bus.rf_addr_o), 32'd9);
        check_eq("sc_pop_we",   32'(bus.rf_we_o),   32'd1);
        check_eq("sc_haz",      32'(bus.hazard_o),  32'd1);
        bus.issue_i = 1'b0;
        tick();
        check_eq("sc_haz_kept", 32'(bus.hazard_o), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_errors);
        $finish;
    end

endmodule
